// File: rtl/wt_stream_buffer.sv
// Writable weight row store that streams a contiguous row window, optionally
// replayed over several passes, to the LSTM MAC array on a valid/ready link.
module wt_stream_buffer #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int DEPTH     = 180,
    parameter int AW        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [UNITS_NUM*D_WL-1:0] wr_data,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [AW:0]               len,
    input  logic [7:0]                npass,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      w_valid,
    input  logic                      w_ready,
    output logic [UNITS_NUM*D_WL-1:0] w_data,
    output logic                      w_last
);

    localparam int          W       = UNITS_NUM * D_WL;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_RUN   = 1'b1;

    logic [W-1:0]  mem [DEPTH];

    logic [0:0]    state;
    logic [AW-1:0] base_q, ptr;
    logic [AW:0]   len_m1, row_cnt;
    logic [7:0]    npass_q, pass_cnt;
    logic          drained;

    // Row store: no reset, read-before-write falls out of the NBA update.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_L))
            mem[wr_addr] <= wr_data;
    end

    logic          idle, start_ok, accept, adv, hs_last, issue, wrap, is_last;
    logic [AW:0]   win_end;
    logic [AW-1:0] cur_base, cur_ptr;
    logic [AW:0]   cur_row, cur_len_m1;
    logic [7:0]    cur_pass, cur_npass;

    assign idle     = (state == S_IDLE);
    assign win_end  = {1'b0, base_addr} + len;
    assign start_ok = (len != '0) && (win_end <= DEPTH_L);
    assign accept   = idle && start && !abort && start_ok;
    assign adv      = !w_valid || w_ready;
    assign hs_last  = w_valid && w_ready && w_last;
    assign issue    = accept || (!idle && adv && !drained && !hs_last);

    // The accepting cycle issues row base directly so the first beat lands one
    // cycle after start; in RUN the latched window state is used instead.
    assign cur_base   = idle ? base_addr : base_q;
    assign cur_ptr    = idle ? base_addr : ptr;
    assign cur_row    = idle ? '0 : row_cnt;
    assign cur_pass   = idle ? '0 : pass_cnt;
    assign cur_len_m1 = idle ? (len - (AW+1)'(1)) : len_m1;
    assign cur_npass  = idle ? npass : npass_q;

    assign wrap    = (cur_row == cur_len_m1);
    assign is_last = wrap && (cur_npass != 8'd0) && (cur_pass == cur_npass - 8'd1);
    assign busy    = (state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            base_q   <= '0;
            ptr      <= '0;
            len_m1   <= '0;
            row_cnt  <= '0;
            npass_q  <= '0;
            pass_cnt <= '0;
            drained  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            w_valid  <= 1'b0;
            w_last   <= 1'b0;
            w_data   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                w_valid <= 1'b0;
                w_last  <= 1'b0;
                drained <= 1'b0;
            end else begin
                if (idle && start && !start_ok)
                    err <= 1'b1;
                if (accept) begin
                    state   <= S_RUN;
                    base_q  <= base_addr;
                    len_m1  <= cur_len_m1;
                    npass_q <= npass;
                end
                if (!idle && hs_last) begin
                    state   <= S_IDLE;
                    done    <= 1'b1;
                    w_valid <= 1'b0;
                    w_last  <= 1'b0;
                    drained <= 1'b0;
                end else if (issue) begin
                    w_data  <= mem[cur_ptr];
                    w_valid <= 1'b1;
                    w_last  <= is_last;
                    drained <= is_last;
                    // pass_cnt stays frozen for endless replay (npass == 0)
                    if (wrap) begin
                        ptr      <= cur_base;
                        row_cnt  <= '0;
                        pass_cnt <= (cur_npass != 8'd0) ? cur_pass + 8'd1 : cur_pass;
                    end else begin
                        ptr      <= cur_ptr + AW'(1);
                        row_cnt  <= cur_row + (AW+1)'(1);
                        pass_cnt <= cur_pass;
                    end
                end else if (!idle && adv) begin
                    w_valid <= 1'b0;
                    w_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wt_stream_buffer.sv
// Scoreboard bench for wt_stream_buffer: expected beats are queued when a
// stream is launched and checked as the consumer accepts them.
module tb_wt_stream_buffer;

    localparam int D_WL      = 24;
    localparam int UNITS_NUM = 5;
    localparam int DEPTH     = 180;
    localparam int AW        = 8;
    localparam int W         = UNITS_NUM * D_WL;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } sb_ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic [7:0]    npass = '0;
    logic          abort = 1'b0;
    logic          busy, done, err, w_valid, w_last;
    logic          w_ready = 1'b1;
    logic [W-1:0]  w_data;

    wt_stream_buffer #(.D_WL(D_WL), .UNITS_NUM(UNITS_NUM), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .len(len), .npass(npass), .abort(abort),
        .busy(busy), .done(done), .err(err), .w_valid(w_valid), .w_ready(w_ready),
        .w_data(w_data), .w_last(w_last)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_hs  = 0;
    sb_ent_t      sb[$];
    sb_ent_t      mon_e;
    logic [W-1:0] model [DEPTH];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] row_val(input int r, input int salt);
        logic [W-1:0] v;
        for (int u = 0; u < UNITS_NUM; u++)
            v[u*D_WL +: D_WL] = D_WL'(r*5 + u + salt);
        return v;
    endfunction

    task automatic push_pass(input int base, input int n, input bit final_pass);
        sb_ent_t e;
        for (int r = 0; r < n; r++) begin
            e.data = model[base + r];
            e.last = final_pass && (r == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_window(input int base, input int n, input int np);
        for (int p = 0; p < np; p++) push_pass(base, n, p == np - 1);
    endtask

    task automatic start_stream(input int base, input int n, input int np);
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); len = (AW+1)'(n); npass = 8'(np);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    // Consumer side: every accepted beat must match the queue head; a stalled
    // beat must already present the head's contents.
    always @(negedge clk) begin
        if (!rst && w_valid) begin
            if (w_ready) begin
                if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
                else begin
                    mon_e = sb.pop_front();
                    chk("beat_data", w_data, mon_e.data);
                    chk("beat_last", w_last, mon_e.last);
                    n_hs++;
                end
            end else if (sb.size() != 0) begin
                chk("stall_data", w_data, sb[0].data);
                chk("stall_last", w_last, sb[0].last);
            end
        end
    end

    initial begin
        int hs0;
        logic [W-1:0] nv;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", w_valid, 0);
        chk("rst_last", w_last, 0);
        chk("rst_data", w_data, 0);
        rst = 1'b0;

        // load rows 0..9 and 170..179
        for (int r = 0; r < DEPTH; r++) begin
            if (r < 10 || r >= 170) begin
                @(posedge clk); #1;
                wr_en = 1'b1; wr_addr = AW'(r); wr_data = row_val(r, 0);
                model[r] = row_val(r, 0);
            end
        end
        @(posedge clk); #1;
        wr_en = 1'b0;

        // 1: basic window, latency and done timing
        push_window(2, 3, 1);
        start_stream(2, 3, 1);
        @(negedge clk); chk("t1_valid0", w_valid, 1); chk("t1_busy", busy, 1);
        @(negedge clk); chk("t1_valid1", w_valid, 1);
        @(negedge clk); chk("t1_last", w_last, 1);
        @(negedge clk); chk("t1_done", done, 1); chk("t1_busy_off", busy, 0);
        chk("t1_valid_off", w_valid, 0);
        chk("t1_sb_empty", sb.size(), 0);

        // 2: alternating backpressure
        push_window(2, 3, 1);
        start_stream(2, 3, 1);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) break;
            w_ready = !w_ready;
        end
        chk("t2_done", done, 1);
        chk("t2_sb_empty", sb.size(), 0);
        w_ready = 1'b1;

        // 3: multi-pass, then endless replay stopped by abort
        push_window(7, 2, 3);
        start_stream(7, 2, 3);
        wait_done("t3", 40);
        for (int i = 0; i < 20; i++) push_pass(7, 2, 0);
        hs0 = n_hs;
        start_stream(7, 2, 0);
        for (int i = 0; i < 100 && n_hs < hs0 + 10; i++) @(posedge clk);
        #1;
        chk("t3_endless_beats", n_hs >= hs0 + 10, 1);
        abort = 1'b1; w_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t5_abort_valid", w_valid, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 0);
        sb.delete();
        w_ready = 1'b1;

        // 4: window bounds
        start_stream(179, 2, 1);
        chk("t4_err_ovf", err, 1); chk("t4_busy_ovf", busy, 0);
        @(posedge clk); #1;
        chk("t4_err_pulse", err, 0);
        start_stream(5, 0, 1);
        chk("t4_err_len0", err, 1);
        push_window(178, 2, 1);
        start_stream(178, 2, 1);
        chk("t4_accept_err", err, 0); chk("t4_accept_busy", busy, 1);
        wait_done("t4", 20);

        // 5: async reset mid-stream, memory must survive
        for (int i = 0; i < 10; i++) push_pass(2, 3, 0);
        start_stream(2, 3, 0);
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", w_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_last", w_last, 0);
        chk("t5_rst_data", w_data, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_window(0, 10, 1);
        start_stream(0, 10, 1);
        wait_done("t5_mem", 40);

        // 6: write row 3 in the cycle it is read
        nv = row_val(3, 1000);
        push_pass(2, 3, 0);
        model[3] = nv;
        push_pass(2, 3, 1);
        start_stream(2, 3, 2);
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = nv;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_done("t6", 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
